bcd_seg_scanner: RTL and testbench



---
 rtl/seg_pkg.sv | 17 +
 rtl/bcd_to_seg.sv | 23 ++
 rtl/bcd_seg_scanner.sv | 84 ++++++++
 tb/tb_bcd_seg_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared BCD width, 7-segment patterns {g,f,e,d,c,b,a} and scanner FSM states.
package seg_pkg;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to 7-segment decode; codes 10..15 show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: snapshots a packed BCD value and scans it one-hot onto a shared 7-segment bus.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module bcd_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        load,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(PRESCALE);
    state_t                      r_state;
    logic [BCD_W*NUM_DIGITS-1:0] r_snap;
    logic [PW-1:0]               r_pre;
    logic [IW-1:0]               r_idx;
    logic                        w_tick;
    logic [IW-1:0]               w_nidx;
    logic [IW-1:0]               w_sel;
    logic [BCD_W*NUM_DIGITS-1:0] w_src;
    logic [BCD_W-1:0]            w_digit;
    logic [6:0]                  w_dec;
    logic [6:0]                  w_seg;

    assign w_tick  = (r_state == SCAN) && (r_pre == PW'(PRESCALE - 1));
    assign w_nidx  = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    // The very first digit after a load from IDLE is always digit 0.
    assign w_sel   = (r_state == IDLE) ? '0 : w_nidx;
    assign w_src   = load ? bcd_in : r_snap;
    assign w_digit = w_src[w_sel*BCD_W +: BCD_W];

    bcd_to_seg u_dec (.i_bcd(w_digit), .o_seg(w_dec));

`ifdef LEAD_ZERO_BLANK_EN
    logic w_blank;
    always_comb begin
        w_blank = (w_sel != '0);
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(w_sel) && w_src[k*BCD_W +: BCD_W] != '0) w_blank = 1'b0;
    end
    assign w_seg = w_blank ? SEG_OFF : w_dec;
`else
    assign w_seg = w_dec;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_snap     <= '0;
            r_pre      <= '0;
            r_idx      <= '0;
            seg        <= SEG_OFF;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (r_state == IDLE) begin
                if (load) begin
                    r_state <= SCAN;
                    r_snap  <= bcd_in;
                    r_idx   <= '0;
                    r_pre   <= '0;
                    an      <= NUM_DIGITS'(1);
                    seg     <= w_seg;
                end
            end else begin
                if (load) r_snap <= bcd_in;
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
                if (w_tick) begin
                    r_idx      <= w_nidx;
                    an         <= NUM_DIGITS'(1) << w_nidx;
                    seg        <= w_seg;
                    frame_done <= (w_nidx == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb_bcd_seg_scanner: randomized and directed checks of bcd_seg_scanner against a time-based reference model.
module tb_bcd_seg_scanner;
    localparam int N = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bit          m_act;
    int          m_t;
    int          m_idx;
    logic [15:0] m_snap;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    bcd_seg_scanner #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [15:0] v, input int k);
        int d;
        d = int'((v >> (4 * k)) & 16'hF);
`ifdef LEAD_ZERO_BLANK_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) return 7'h00;
`endif
        return (d > 9) ? 7'h40 : pat[d];
    endfunction

    function automatic logic [6:0] lead_zero(input int k);
`ifdef LEAD_ZERO_BLANK_EN
        return (k > 0) ? 7'h00 : 7'h3F;
`else
        return 7'h3F;
`endif
    endfunction

    // Drive one cycle and advance the model: the displayed digit is a function of elapsed time since load.
    task automatic cyc(input logic r, input logic l, input logic [15:0] b);
        logic [15:0] src;
        rst = r;
        load = l;
        bcd_in = b;
        @(posedge clk);
        if (!r) begin
            m_act = 0; m_snap = '0; m_idx = 0; m_t = 0;
            exp_seg = '0; exp_an = '0; exp_fd = 1'b0;
        end else if (!m_act) begin
            exp_fd = 1'b0;
            if (l) begin
                m_act = 1; m_snap = b; m_t = 0; m_idx = 0;
                exp_an = 4'b0001; exp_seg = dec(b, 0);
            end
        end else begin
            src = l ? b : m_snap;
            m_t++;
            exp_fd = 1'b0;
            if (m_t % P == 0) begin
                m_idx = (m_t / P) % N;
                exp_an = 4'(1 << m_idx);
                exp_seg = dec(src, m_idx);
                exp_fd = (m_idx == 0);
            end
            if (l) m_snap = b;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 22; i++) begin
            cyc(i >= 2, 1'b0, 16'h1234);
            checks++;
            if (seg !== 7'h00 || an !== 4'b0000 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got seg=%h an=%b fd=%b, want 00 0000 0", i, seg, an, frame_done);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0] bs [0:4] = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h66};
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) cyc(1'b1, 1'b0, 16'h0);
            checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                errors++;
                $display("FAIL basic model t=%0d: got seg=%h an=%b fd=%b, want %h %b %b", i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (i % 4 == 0) begin
                checks++;
                if (seg !== bs[i/4] || an !== 4'(1 << ((i / 4) % 4)) || frame_done !== (i == 16)) begin
                    errors++;
                    $display("FAIL basic boundary t=%0d: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                             i, seg, an, frame_done, bs[i/4], 4'(1 << ((i / 4) % 4)), (i == 16));
                end
            end
        end
    endtask

    task automatic test_invalid_and_blank(input logic [15:0] v, input logic [6:0] d1, input string nm);
        logic [6:0] want;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, v);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) cyc(1'b1, 1'b0, 16'h0);
            want = (i / 4 == 1) ? d1 : lead_zero(i / 4);
            checks++;
            if (seg !== want || an !== 4'(1 << (i / 4)) || seg !== exp_seg) begin
                errors++;
                $display("FAIL %s t=%0d: got seg=%h an=%b, want seg=%h an=%b", nm, i, seg, an, want, 4'(1 << (i / 4)));
            end
        end
    endtask

    task automatic test_load_during_scan();
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h1234);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h5678);
        checks++;
        if (seg !== 7'h4F || an !== 4'b0010) begin
            errors++;
            $display("FAIL load_scan hold: got seg=%h an=%b, want 4f 0010", seg, an);
        end
        cyc(1'b1, 1'b0, 16'h0);
        checks++;
        if (seg !== 7'h4F || an !== 4'b0010) begin
            errors++;
            $display("FAIL load_scan hold2: got seg=%h an=%b, want 4f 0010", seg, an);
        end
        cyc(1'b1, 1'b0, 16'h0);
        checks++;
        if (seg !== 7'h7D || an !== 4'b0100 || seg !== exp_seg) begin
            errors++;
            $display("FAIL load_scan boundary: got seg=%h an=%b, want 7d 0100", seg, an);
        end
    endtask

    task automatic test_load_on_tick();
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h1111);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h0090);
        checks++;
        if (seg !== 7'h6F || an !== 4'b0010 || seg !== exp_seg) begin
            errors++;
            $display("FAIL load_tick: got seg=%h an=%b, want 6f 0010", seg, an);
        end
    endtask

    task automatic test_reset_mid_scan();
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h1234);
        for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h9999);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc(1'b1, 1'b0, 16'h4321);
            checks++;
            if (seg !== 7'h00 || an !== 4'b0000 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got seg=%h an=%b fd=%b, want 00 0000 0", i, seg, an, frame_done);
            end
        end
        cyc(1'b1, 1'b1, 16'h0005);
        checks++;
        if (seg !== 7'h6D || an !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid reload: got seg=%h an=%b, want 6d 0001", seg, an);
        end
    endtask

    task automatic test_random();
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), 16'($urandom));
            checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                errors++;
                $display("FAIL random cycle %0d: got seg=%h an=%b fd=%b, want %h %b %b", i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b1, 16'($urandom));
            checks++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got seg=%h an=%b fd=%b, want %h %b %b", i, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_invalid_and_blank(16'h00A0, 7'h40, "invalid");
        test_invalid_and_blank(16'h0070, 7'h07, "blank");
        test_load_during_scan();
        test_load_on_tick();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
